// File: rtl/imm_generator.sv
// Purpose : RV32I decode-stage immediate generator (format classify, assemble, sign-extend).
// Latency : 1 cycle from inst_valid/inst to imm_valid/extended_immediate/imm_fmt/imm_illegal.
// Backpr. : none; accepts one instruction every cycle, results hold while inst_valid is low.
//
// Ports:
//   clk, rst_n          - rising-edge clock, asynchronous active-low reset
//   inst_valid, inst    - instruction word and its qualifier
//   extended_immediate  - immediate sign-extended to DATA_WIDTH (0 for NONE)
//   imm_valid           - outputs refer to the instruction captured on the previous edge
//   imm_fmt             - 0=NONE 1=I 2=SHAMT 3=S 4=B 5=U 6=J
//   imm_illegal         - opcode carries no immediate or is not recognised
module imm_generator #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inst_valid,
    input  logic [31:0]           inst,
    output logic [DATA_WIDTH-1:0] extended_immediate,
    output logic                  imm_valid,
    output logic [2:0]            imm_fmt,
    output logic                  imm_illegal
);

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_SHAMT = 3'd2,
        FMT_S     = 3'd3,
        FMT_B     = 3'd4,
        FMT_U     = 3'd5,
        FMT_J     = 3'd6
    } imm_fmt_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    imm_fmt_e              fmt_nxt;
    logic [31:0]           imm32;
    logic [DATA_WIDTH-1:0] imm_ext;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    // Format classification. Only the 32-bit encoding space (inst[1:0]==11)
    // is decoded; compressed/invalid words fall through to NONE.
    always_comb begin
        fmt_nxt = FMT_NONE;
        if (inst[1:0] == 2'b11) begin
            case (opcode)
                OP_IMM: begin
                    // SLLI/SRLI/SRAI carry a 5-bit shamt; funct7 (incl. SRAI's
                    // bit 30) is not part of the immediate.
                    if (funct3 == 3'b001 || funct3 == 3'b101) fmt_nxt = FMT_SHAMT;
                    else                                      fmt_nxt = FMT_I;
                end
                OP_LOAD, OP_JALR, OP_SYSTEM: fmt_nxt = FMT_I;
                OP_STORE:                    fmt_nxt = FMT_S;
                OP_BRANCH:                   fmt_nxt = FMT_B;
                OP_LUI, OP_AUIPC:            fmt_nxt = FMT_U;
                OP_JAL:                      fmt_nxt = FMT_J;
                default:                     fmt_nxt = FMT_NONE;
            endcase
        end
    end

    // Immediate assembly to 32 bits; every signed format uses inst[31] as MSB.
    always_comb begin
        imm32 = '0;
        case (fmt_nxt)
            FMT_I:     imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_SHAMT: imm32 = {27'd0, inst[24:20]};
            FMT_S:     imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:     imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:     imm32 = {inst[31:12], 12'd0};
            FMT_J:     imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:   imm32 = '0;
        endcase
    end

    // Widening cast of a signed operand replicates bit 31 up to DATA_WIDTH;
    // SHAMT has bit 31 clear, so it stays zero-extended.
    assign imm_ext = DATA_WIDTH'($signed(imm32));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            extended_immediate <= '0;
            imm_valid          <= 1'b0;
            imm_fmt            <= 3'd0;
            imm_illegal        <= 1'b0;
        end else begin
            imm_valid <= inst_valid;
            // Payload only updates on a captured instruction; otherwise held.
            if (inst_valid) begin
                extended_immediate <= imm_ext;
                imm_fmt            <= fmt_nxt;
                imm_illegal        <= (fmt_nxt == FMT_NONE);
            end
        end
    end

endmodule

// File: tb/tb_imm_generator.sv
// Purpose : self-checking bench for imm_generator (directed table + random vs reference model).
// Latency : checks outputs one edge after presentation, sampled on the falling edge.
// Backpr. : n/a; bench drives inputs on falling edges.
module tb_imm_generator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_valid = 1'b0;
    logic [31:0] inst = '0;
    logic [31:0] extended_immediate;
    logic        imm_valid;
    logic [2:0]  imm_fmt;
    logic        imm_illegal;

    int checks = 0;
    int errs   = 0;

    imm_generator #(.DATA_WIDTH(32)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .inst_valid         (inst_valid),
        .inst               (inst),
        .extended_immediate (extended_immediate),
        .imm_valid          (imm_valid),
        .imm_fmt            (imm_fmt),
        .imm_illegal        (imm_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } dec_t;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    // Expected output register contents.
    dec_t exp_q;
    logic exp_vld;

    // Reference decode built from the ISA field definitions using integer arithmetic.
    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t d;
        int   v;
        int   sgn;
        v     = 0;
        sgn   = w[31] ? 1 : 0;
        d.fmt = 3'd0;
        if (w[1:0] == 2'b11) begin
            case (w[6:0])
                7'h13: begin
                    if (w[14:12] == 3'd1 || w[14:12] == 3'd5) begin
                        d.fmt = 3'd2;
                        v = int'(w[24:20]);
                    end else begin
                        d.fmt = 3'd1;
                        v = int'(w[31:20]) - sgn * 4096;
                    end
                end
                7'h03, 7'h67, 7'h73: begin
                    d.fmt = 3'd1;
                    v = int'(w[31:20]) - sgn * 4096;
                end
                7'h23: begin
                    d.fmt = 3'd3;
                    v = int'(w[31:25]) * 32 + int'(w[11:7]) - sgn * 4096;
                end
                7'h63: begin
                    d.fmt = 3'd4;
                    v = -sgn * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
                end
                7'h37, 7'h17: begin
                    d.fmt = 3'd5;
                    v = int'(w[31:12]) * 4096;
                end
                7'h6F: begin
                    d.fmt = 3'd6;
                    v = -sgn * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
                end
                default: d.fmt = 3'd0;
            endcase
        end
        d.ill = (d.fmt == 3'd0);
        d.imm = 32'(v);
        return d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive at a falling edge, let one rising edge pass, update the model.
    task automatic apply(input logic v, input logic [31:0] w);
        inst_valid = v;
        inst       = w;
        @(negedge clk);
        exp_vld = v;
        if (v) exp_q = ref_decode(w);
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".valid"}, 32'(imm_valid), 32'(exp_vld));
        chk({tag, ".imm"},   extended_immediate, exp_q.imm);
        chk({tag, ".fmt"},   32'(imm_fmt), 32'(exp_q.fmt));
        chk({tag, ".ill"},   32'(imm_illegal), 32'(exp_q.ill));
    endtask

    task automatic cmp_vec(input vec_t t);
        chk({t.name, ".imm"}, extended_immediate, t.imm);
        chk({t.name, ".fmt"}, 32'(imm_fmt), 32'(t.fmt));
        chk({t.name, ".ill"}, 32'(imm_illegal), 32'(t.ill));
    endtask

    vec_t vecs[$];
    logic [6:0] ops [9] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    initial begin
        vecs.push_back('{"i_pos",   32'h555FFF93, 32'h00000555, 3'd1, 1'b0});
        vecs.push_back('{"i_neg",   32'hD55FFF93, 32'hFFFFFD55, 3'd1, 1'b0});
        vecs.push_back('{"slli",    32'h015F9F93, 32'd21,       3'd2, 1'b0});
        vecs.push_back('{"srli",    32'h015FDF93, 32'd21,       3'd2, 1'b0});
        vecs.push_back('{"srai",    32'h415FDF93, 32'd21,       3'd2, 1'b0});
        vecs.push_back('{"s_pos",   32'h55FFFAA3, 32'h00000555, 3'd3, 1'b0});
        vecs.push_back('{"s_neg",   32'hD5FFFAA3, 32'hFFFFFD55, 3'd3, 1'b0});
        vecs.push_back('{"b_pos",   32'h2BFFF5E3, 32'h00000AAA, 3'd4, 1'b0});
        vecs.push_back('{"b_neg",   32'hABFFF5E3, 32'hFFFFFAAA, 3'd4, 1'b0});
        vecs.push_back('{"lui",     32'h55555FB7, 32'h55555000, 3'd5, 1'b0});
        vecs.push_back('{"jal",     32'hD5455FEF, 32'hFFF55554, 3'd6, 1'b0});
        vecs.push_back('{"rtype",   32'h00B50533, 32'h00000000, 3'd0, 1'b1});
        vecs.push_back('{"fence",   32'h0FF0000F, 32'h00000000, 3'd0, 1'b1});
        vecs.push_back('{"cmprs",   32'hFFFFFF91, 32'h00000000, 3'd0, 1'b1});
        vecs.push_back('{"load",    32'hFFF12083, 32'hFFFFFFFF, 3'd1, 1'b0});
        vecs.push_back('{"auipc",   32'h80000017, 32'h80000000, 3'd5, 1'b0});

        exp_q   = '0;
        exp_vld = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst.imm",   extended_immediate, 32'd0);
        chk("rst.valid", 32'(imm_valid), 32'd0);
        chk("rst.fmt",   32'(imm_fmt), 32'd0);
        chk("rst.ill",   32'(imm_illegal), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Isolated vectors: result one edge later, then held with valid low.
        foreach (vecs[k]) begin
            apply(1'b1, vecs[k].inst);
            chk({vecs[k].name, ".valid"}, 32'(imm_valid), 32'd1);
            cmp_vec(vecs[k]);
            apply(1'b0, $urandom);
            chk({vecs[k].name, ".drop"}, 32'(imm_valid), 32'd0);
            cmp_vec(vecs[k]);
        end

        // Back-to-back stream: one result per cycle.
        foreach (vecs[k]) begin
            apply(1'b1, vecs[k].inst);
            chk({"b2b.", vecs[k].name, ".valid"}, 32'(imm_valid), 32'd1);
            cmp_vec(vecs[k]);
        end

        // Mid-stream asynchronous reset.
        apply(1'b1, vecs[1].inst);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.imm",   extended_immediate, 32'd0);
        chk("arst.valid", 32'(imm_valid), 32'd0);
        chk("arst.fmt",   32'(imm_fmt), 32'd0);
        chk("arst.ill",   32'(imm_illegal), 32'd0);
        exp_q   = '0;
        exp_vld = 1'b0;
        @(negedge clk);
        cmp_model("arst_hold");
        rst_n = 1'b1;
        // First valid instruction after release.
        apply(1'b1, vecs[10].inst);
        chk("post_rst.valid", 32'(imm_valid), 32'd1);
        cmp_vec(vecs[10]);

        // Randomised traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 9) < 8) w[6:0] = ops[$urandom_range(0, 8)];
            apply($urandom_range(0, 3) != 0, w);
            cmp_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end

endmodule

// File: doc/imm_generator.md
Name: imm_generator

Overview:
- RV32I immediate generator for the decode stage.
- Takes a 32-bit instruction word, classifies its immediate format from the opcode, and assembles the immediate.
- Sign-extends the immediate to DATA_WIDTH.
- Result is registered, with a valid flag, one cycle after the instruction is presented.

Parameters:
- DATA_WIDTH, 32, width of the extended immediate. Legal values ≥ 32.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- inst_valid  in  1  inst is valid this cycle.
- inst  in  32  instruction word.
- extended_immediate  out  DATA_WIDTH  registered immediate.
- imm_valid  out  1  extended_immediate/imm_fmt/imm_illegal are valid.
- imm_fmt  out  3  format: 0=NONE, 1=I, 2=SHAMT, 3=S, 4=B, 5=U, 6=J.
- imm_illegal  out  1  opcode has no immediate or is unrecognised.

Behaviour:
- Reset: clk and rst_n as named above; reset is asynchronous and active-low. While rst_n=0, all outputs are 0 (extended_immediate=0, imm_valid=0, imm_fmt=0, imm_illegal=0).
- Latency: 1 cycle. Rising edge with inst_valid=1 captures the decode of inst.
  - imm_valid=1 for exactly the following cycle, unless inst_valid stays high.
- Edge with inst_valid=0: imm_valid←0; extended_immediate, imm_fmt and imm_illegal hold their previous values.
- Back-to-back valid instructions produce one result per cycle.
- Decode on inst[6:0]:
  - 0010011 OP-IMM:
    - funct3 (inst[14:12]) = 001 or 101 → SHAMT: imm = zero-extended inst[24:20]. inst[31:25] ignored, so SRAI's bit 30 does not appear.
    - Other funct3 → I: imm = sext(inst[31:20]).
  - 0000011 LOAD, 1100111 JALR, 1110011 SYSTEM → I: sext(inst[31:20]).
  - 0100011 STORE → S: sext({inst[31:25], inst[11:7]}).
  - 1100011 BRANCH → B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}). Bit 0 is always 0.
  - 0110111 LUI, 0010111 AUIPC → U: {inst[31:12], 12'b0}, sign-extended from bit 31 when DATA_WIDTH > 32.
  - 1101111 JAL → J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - Any other opcode (R-type 0110011, FENCE 0001111, unknown) → NONE: imm=0, imm_illegal=1.
- sext replicates the immediate's MSB (always inst[31]) up to DATA_WIDTH.
- Decoded bits come only from inst; no dependence on prior state other than the output register.
- inst[1:0] ≠ 11 (compressed/invalid) → NONE, imm_illegal=1.
- Reset asserted mid-stream clears outputs immediately. The first valid instruction after deassertion yields its result on the next edge.

Test Plan (all after reset release; results checked one edge after presentation with inst_valid=1):
1. I-type, inst=0x555FFF93 → 0x00000555 (1365), fmt=I. inst=0xD55FFF93 → 0xFFFFFD55 (−683).
2. Shifts: SLLI inst=0x015F9F93 → 21, fmt=SHAMT. SRLI inst=0x015FDF93 → 21. SRAI (bit30=1) inst=0x415FDF93 → 21.
3. S-type: inst=0x55FFFAA3 → 0x00000555 (1365), fmt=S. inst=0xD5FFFAA3 → 0xFFFFFD55 (−683).
4. B-type: inst=0x2BFFF5E3 → 0x00000AAA (2730), fmt=B. inst=0xABFFF5E3 → 0xFFFFFAAA (−1366).
5. U/J:
   - LUI inst=0x55555FB7 → 0x55555000, fmt=U.
   - JAL inst=0xD5455FEF → 0xFFF55554 (−699052), fmt=J.
   - R-type inst=0x00B50533 → imm=0, imm_illegal=1.
6. Handshake and reset:
   - Valid inst then inst_valid=0 → imm_valid drops, value held.
   - rst_n pulsed low mid-stream → all outputs 0 asynchronously.
   - Back-to-back stream of cases 1–5 → one correct result per cycle.
